exec_unit_pipelined: RTL and testbench

Parametrised successor to the single-cycle 4-bit execution unit.
- Adds a register file of NUM_REGS registers, each DATA_WIDTH wide.
- Adds an ACC_WIDTH accumulator with sticky-free zero and overflow flags.
- Adds multi-cycle shift execution with a valid/ready instruction handshake and a done pulse.
- Sits between the SPI/program-ROM fetch logic, which supplies opcode/operands, and the output pins.

---
 rtl/exec_unit_pipelined.sv | 210 +++++++++++++++++++++
 tb/tb_exec_unit_pipelined.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/exec_unit_pipelined.sv
// Execution unit with register file, accumulator, multi-cycle shifts and an optional
// shift-add multiplier (opcode 14) compiled in when EXEC_UNIT_MUL_EN is defined.
module exec_unit_pipelined #(
    parameter int DATA_WIDTH = 4,
    parameter int ACC_WIDTH  = 8,
    parameter int NUM_REGS   = 4,
    parameter int SEL_WIDTH  = $clog2(NUM_REGS)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  instr_valid,
    output logic                  instr_ready,
    input  logic [3:0]            opcode,
    input  logic [SEL_WIDTH-1:0]  rd_sel,
    input  logic [SEL_WIDTH-1:0]  rs_sel,
    input  logic [DATA_WIDTH-1:0] imm,
    output logic                  done,
    output logic                  skip_next,
    output logic [ACC_WIDTH-1:0]  cpu_out,
    output logic                  zero_flag,
    output logic                  ovf_flag
);
    // Counter must hold both a full shift amount and DATA_WIDTH multiply steps.
    localparam int CW = DATA_WIDTH + 1;

    localparam logic [3:0] OP_LDR  = 4'd1;
    localparam logic [3:0] OP_ADD  = 4'd2;
    localparam logic [3:0] OP_SUB  = 4'd3;
    localparam logic [3:0] OP_AND  = 4'd4;
    localparam logic [3:0] OP_OR   = 4'd5;
    localparam logic [3:0] OP_XOR  = 4'd6;
    localparam logic [3:0] OP_INV  = 4'd7;
    localparam logic [3:0] OP_CLR  = 4'd8;
    localparam logic [3:0] OP_LSH  = 4'd9;
    localparam logic [3:0] OP_RSH  = 4'd10;
    localparam logic [3:0] OP_OUT  = 4'd11;
    localparam logic [3:0] OP_SNZR = 4'd12;
    localparam logic [3:0] OP_SNZA = 4'd13;

    typedef enum logic [1:0] {IDLE, SHIFT, MUL} state_t;
    state_t state_reg, state_next;

    logic [DATA_WIDTH-1:0] regs [NUM_REGS];
    logic [ACC_WIDTH-1:0]  acc_reg;
    logic [CW-1:0]         count_reg;
    logic                  shift_left_reg;

    logic                  accept;
    logic                  shift_multi;
    logic                  last_step;
    logic                  shift_lost;
    logic [DATA_WIDTH-1:0] rs_val;
    logic [ACC_WIDTH-1:0]  rs_ext;
    logic [ACC_WIDTH-1:0]  shifted;
    logic [ACC_WIDTH:0]    add_sum;
    logic [ACC_WIDTH:0]    sub_diff;

    assign accept      = instr_valid && instr_ready;
    assign shift_multi = ((opcode == OP_LSH) || (opcode == OP_RSH)) && (imm != '0);
    assign last_step   = (count_reg == CW'(1));
    assign rs_val      = regs[rs_sel];
    assign rs_ext      = ACC_WIDTH'(rs_val);
    assign add_sum     = {1'b0, acc_reg} + {1'b0, rs_ext};
    assign sub_diff    = {1'b0, acc_reg} - {1'b0, rs_ext};
    assign shifted     = shift_left_reg ? (acc_reg << 1) : (acc_reg >> 1);
    assign shift_lost  = shift_left_reg ? acc_reg[ACC_WIDTH-1] : acc_reg[0];

`ifdef EXEC_UNIT_MUL_EN
    localparam logic [3:0] OP_MUL = 4'd14;
    // Product kept wide enough that anything above ACC_WIDTH signals overflow.
    localparam int PW = 2 * DATA_WIDTH + ACC_WIDTH;
    logic [PW-1:0]         mcand_reg;
    logic [PW-1:0]         prod_reg;
    logic [PW-1:0]         prod_sum;
    logic [DATA_WIDTH-1:0] mplier_reg;

    assign prod_sum = mplier_reg[0] ? (prod_reg + mcand_reg) : prod_reg;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_reg <= IDLE;
        else        state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: begin
                if (accept && shift_multi) state_next = SHIFT;
`ifdef EXEC_UNIT_MUL_EN
                else if (accept && (opcode == OP_MUL)) state_next = MUL;
`endif
            end
            SHIFT, MUL: if (last_step) state_next = IDLE;
            default:    state_next = IDLE;
        endcase
    end

    always_comb begin
        instr_ready = (state_reg == IDLE);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
            acc_reg        <= '0;
            cpu_out        <= '0;
            count_reg      <= '0;
            shift_left_reg <= 1'b0;
            zero_flag      <= 1'b0;
            ovf_flag       <= 1'b0;
            done           <= 1'b0;
            skip_next      <= 1'b0;
`ifdef EXEC_UNIT_MUL_EN
            mcand_reg      <= '0;
            prod_reg       <= '0;
            mplier_reg     <= '0;
`endif
        end else begin
            done      <= 1'b0;
            skip_next <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (accept) begin
                        done <= 1'b1;
                        case (opcode)
                            OP_LDR: regs[rd_sel] <= imm;
                            OP_ADD: begin
                                acc_reg   <= add_sum[ACC_WIDTH-1:0];
                                ovf_flag  <= add_sum[ACC_WIDTH];
                                zero_flag <= (add_sum[ACC_WIDTH-1:0] == '0);
                            end
                            OP_SUB: begin
                                acc_reg   <= sub_diff[ACC_WIDTH-1:0];
                                ovf_flag  <= sub_diff[ACC_WIDTH];
                                zero_flag <= (sub_diff[ACC_WIDTH-1:0] == '0);
                            end
                            OP_AND: begin
                                acc_reg   <= acc_reg & rs_ext;
                                zero_flag <= ((acc_reg & rs_ext) == '0);
                            end
                            OP_OR: begin
                                acc_reg   <= acc_reg | rs_ext;
                                zero_flag <= ((acc_reg | rs_ext) == '0);
                            end
                            OP_XOR: begin
                                acc_reg   <= acc_reg ^ rs_ext;
                                zero_flag <= ((acc_reg ^ rs_ext) == '0);
                            end
                            OP_INV: begin
                                acc_reg   <= ~acc_reg;
                                zero_flag <= (~acc_reg == '0);
                            end
                            OP_CLR: begin
                                acc_reg   <= '0;
                                zero_flag <= 1'b1;
                                ovf_flag  <= 1'b0;
                            end
                            OP_LSH, OP_RSH: begin
                                ovf_flag <= 1'b0;
                                if (shift_multi) begin
                                    done           <= 1'b0;
                                    count_reg      <= CW'(imm);
                                    shift_left_reg <= (opcode == OP_LSH);
                                end else begin
                                    zero_flag <= (acc_reg == '0);
                                end
                            end
                            OP_OUT:  cpu_out   <= acc_reg;
                            OP_SNZR: skip_next <= (rs_val == '0);
                            OP_SNZA: skip_next <= (acc_reg == '0);
`ifdef EXEC_UNIT_MUL_EN
                            OP_MUL: begin
                                done       <= 1'b0;
                                count_reg  <= CW'(DATA_WIDTH);
                                mcand_reg  <= PW'(rs_val);
                                mplier_reg <= regs[rd_sel];
                                prod_reg   <= '0;
                            end
`endif
                            default: ;
                        endcase
                    end
                end
                SHIFT: begin
                    acc_reg   <= shifted;
                    ovf_flag  <= ovf_flag | shift_lost;
                    zero_flag <= (shifted == '0);
                    count_reg <= count_reg - CW'(1);
                    if (last_step) done <= 1'b1;
                end
`ifdef EXEC_UNIT_MUL_EN
                MUL: begin
                    prod_reg   <= prod_sum;
                    mcand_reg  <= mcand_reg << 1;
                    mplier_reg <= mplier_reg >> 1;
                    count_reg  <= count_reg - CW'(1);
                    if (last_step) begin
                        acc_reg   <= prod_sum[ACC_WIDTH-1:0];
                        ovf_flag  <= |prod_sum[PW-1:ACC_WIDTH];
                        zero_flag <= (prod_sum[ACC_WIDTH-1:0] == '0);
                        done      <= 1'b1;
                    end
                end
`endif
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_exec_unit_pipelined.sv
// Directed bench for exec_unit_pipelined (DATA_WIDTH=4, ACC_WIDTH=8, NUM_REGS=4);
// the accumulator is observed through OUT -> cpu_out.
module tb_exec_unit_pipelined;
    logic       clk = 1'b0;
    logic       reset;
    logic       instr_valid;
    logic       instr_ready;
    logic [3:0] opcode;
    logic [1:0] rd_sel;
    logic [1:0] rs_sel;
    logic [3:0] imm;
    logic       done;
    logic       skip_next;
    logic [7:0] cpu_out;
    logic       zero_flag;
    logic       ovf_flag;
    logic       saw_done;

    int total = 0;
    int bad   = 0;

    localparam logic [3:0] OP_LDR = 4'd1,  OP_ADD = 4'd2,  OP_SUB = 4'd3;
    localparam logic [3:0] OP_CLR = 4'd8,  OP_LSH = 4'd9,  OP_RSH = 4'd10;
    localparam logic [3:0] OP_OUT = 4'd11, OP_SNZR = 4'd12, OP_SNZA = 4'd13;
    localparam logic [3:0] OP_MUL = 4'd14;

    always #5 clk = ~clk;

    exec_unit_pipelined #(
        .DATA_WIDTH(4),
        .ACC_WIDTH (8),
        .NUM_REGS  (4)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .instr_valid(instr_valid),
        .instr_ready(instr_ready),
        .opcode     (opcode),
        .rd_sel     (rd_sel),
        .rs_sel     (rs_sel),
        .imm        (imm),
        .done       (done),
        .skip_next  (skip_next),
        .cpu_out    (cpu_out),
        .zero_flag  (zero_flag),
        .ovf_flag   (ovf_flag)
    );

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%02h expected=%02h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [3:0] op, input logic [1:0] rd, input logic [1:0] rs,
                         input logic [3:0] im);
        instr_valid = 1'b1;
        opcode      = op;
        rd_sel      = rd;
        rs_sel      = rs;
        imm         = im;
    endtask

    task automatic show(input string tag);
        $display("%s: op=%0d rd=%0d rs=%0d imm=%0d cpu_out=%02h zero=%0b ovf=%0b skip=%0b",
                 tag, opcode, rd_sel, rs_sel, imm, cpu_out, zero_flag, ovf_flag, skip_next);
    endtask

    // Single-cycle instruction: done and skip_next sampled in the cycle after acceptance.
    task automatic exec1(input string tag, input logic [3:0] op, input logic [1:0] rd,
                         input logic [1:0] rs, input logic [3:0] im, input logic skip_exp);
        check({tag, " ready"}, 8'(instr_ready), 8'd1);
        drive(op, rd, rs, im);
        step();
        instr_valid = 1'b0;
        check({tag, " done"}, 8'(done), 8'd1);
        check({tag, " skip"}, 8'(skip_next), 8'(skip_exp));
        show(tag);
        step();
        check({tag, " done_width"}, 8'(done), 8'd0);
        check({tag, " skip_low"}, 8'(skip_next), 8'd0);
    endtask

    // Multi-cycle instruction held valid until done; counts cycles with instr_ready low.
    task automatic exec_multi(input string tag, input logic [3:0] op, input logic [1:0] rd,
                              input logic [1:0] rs, input logic [3:0] im, input int busy_exp);
        int   busy = 0;
        logic seen = 1'b0;
        check({tag, " ready"}, 8'(instr_ready), 8'd1);
        drive(op, rd, rs, im);
        step();
        for (int i = 0; i < 40; i++) begin
            if (done === 1'b1) begin
                seen = 1'b1;
                break;
            end
            if (instr_ready === 1'b0) busy++;
            step();
        end
        instr_valid = 1'b0;
        check({tag, " done_seen"}, 8'(seen), 8'd1);
        check({tag, " busy_cycles"}, 8'(busy), 8'(busy_exp));
        check({tag, " skip"}, 8'(skip_next), 8'd0);
        show(tag);
        step();
        check({tag, " done_width"}, 8'(done), 8'd0);
        check({tag, " ready_after"}, 8'(instr_ready), 8'd1);
    endtask

    task automatic flags(input string tag, input logic z, input logic o);
        check({tag, " zero"}, 8'(zero_flag), 8'(z));
        check({tag, " ovf"}, 8'(ovf_flag), 8'(o));
    endtask

    task automatic out_chk(input string tag, input logic [7:0] exp);
        exec1({tag, " out"}, OP_OUT, 2'd0, 2'd0, 4'd0, 1'b0);
        check({tag, " cpu_out"}, cpu_out, exp);
    endtask

    initial begin
        reset       = 1'b0;
        instr_valid = 1'b0;
        opcode      = 4'd0;
        rd_sel      = 2'd0;
        rs_sel      = 2'd0;
        imm         = 4'd0;
        saw_done    = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst cpu_out", cpu_out, 8'h00);
        flags("rst", 1'b0, 1'b0);
        check("rst done", 8'(done), 8'd0);
        check("rst skip", 8'(skip_next), 8'd0);
        check("rst ready", 8'(instr_ready), 8'd1);
        reset = 1'b1;
        step();

        // Load, clear, add, output
        exec1("ldr r0", OP_LDR, 2'd0, 2'd0, 4'd9, 1'b0);
        exec1("ldr r1", OP_LDR, 2'd1, 2'd0, 4'd7, 1'b0);
        exec1("clr", OP_CLR, 2'd0, 2'd0, 4'd0, 1'b0);
        flags("clr", 1'b1, 1'b0);
        exec1("add r0", OP_ADD, 2'd0, 2'd0, 4'd0, 1'b0);
        flags("add r0", 1'b0, 1'b0);
        exec1("add r1", OP_ADD, 2'd0, 2'd1, 4'd0, 1'b0);
        flags("add r1", 1'b0, 1'b0);
        out_chk("t1", 8'h10);

        // Borrow then carry
        exec1("clr", OP_CLR, 2'd0, 2'd0, 4'd0, 1'b0);
        exec1("sub r1", OP_SUB, 2'd0, 2'd1, 4'd0, 1'b0);
        flags("sub r1", 1'b0, 1'b1);
        out_chk("t2a", 8'hF9);
        exec1("add r1", OP_ADD, 2'd0, 2'd1, 4'd0, 1'b0);
        flags("add carry", 1'b1, 1'b1);
        out_chk("t2b", 8'h00);

        // Multi-cycle shifts
        exec1("clr", OP_CLR, 2'd0, 2'd0, 4'd0, 1'b0);
        exec1("add r0", OP_ADD, 2'd0, 2'd0, 4'd0, 1'b0);
        exec1("add r1", OP_ADD, 2'd0, 2'd1, 4'd0, 1'b0);
        exec_multi("lsh3", OP_LSH, 2'd0, 2'd0, 4'd3, 3);
        flags("lsh3", 1'b0, 1'b0);
        out_chk("t3a", 8'h80);
        exec_multi("lsh1", OP_LSH, 2'd0, 2'd0, 4'd1, 1);
        flags("lsh1", 1'b1, 1'b1);
        exec1("rsh0", OP_RSH, 2'd0, 2'd0, 4'd0, 1'b0);
        flags("rsh0", 1'b1, 1'b0);
        out_chk("t3b", 8'h00);
        exec1("add r1", OP_ADD, 2'd0, 2'd1, 4'd0, 1'b0);
        exec1("rsh0 nz", OP_RSH, 2'd0, 2'd0, 4'd0, 1'b0);
        flags("rsh0 nz", 1'b0, 1'b0);
        out_chk("t3c", 8'h07);

        // Conditional skips
        exec1("ldr r2", OP_LDR, 2'd2, 2'd0, 4'd0, 1'b0);
        exec1("snzr r2", OP_SNZR, 2'd0, 2'd2, 4'd0, 1'b1);
        exec1("snzr r0", OP_SNZR, 2'd0, 2'd0, 4'd0, 1'b0);
        exec1("snza nz", OP_SNZA, 2'd0, 2'd0, 4'd0, 1'b0);
        exec1("clr", OP_CLR, 2'd0, 2'd0, 4'd0, 1'b0);
        exec1("snza z", OP_SNZA, 2'd0, 2'd0, 4'd0, 1'b1);

        // Reset in the middle of a shift
        exec1("ldr r3", OP_LDR, 2'd3, 2'd0, 4'd1, 1'b0);
        exec1("add r3", OP_ADD, 2'd0, 2'd3, 4'd0, 1'b0);
        out_chk("t5 pre", 8'h01);
        drive(OP_LSH, 2'd0, 2'd0, 4'd5);
        step();
        step();
        check("abort busy", 8'(instr_ready), 8'd0);
        #2;
        reset = 1'b0;
        #1;
        instr_valid = 1'b0;
        check("abort cpu_out", cpu_out, 8'h00);
        flags("abort", 1'b0, 1'b0);
        check("abort done", 8'(done), 8'd0);
        check("abort skip", 8'(skip_next), 8'd0);
        check("abort ready", 8'(instr_ready), 8'd1);
        step();
        reset = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step();
            if (done !== 1'b0) saw_done = 1'b1;
        end
        $display("abort: reset released, done watched for 10 cycles saw_done=%0b", saw_done);
        check("abort no_done", 8'(saw_done), 8'd0);
        check("abort ready_after", 8'(instr_ready), 8'd1);
        exec1("add r0 rst", OP_ADD, 2'd0, 2'd0, 4'd0, 1'b0);
        flags("add r0 rst", 1'b1, 1'b0);
        out_chk("t5 post", 8'h00);

        // Multiply (or NOP when the multiplier is not built)
        exec1("ldr r0", OP_LDR, 2'd0, 2'd0, 4'd9, 1'b0);
        exec1("ldr r1", OP_LDR, 2'd1, 2'd0, 4'd7, 1'b0);
        exec1("add r0", OP_ADD, 2'd0, 2'd0, 4'd0, 1'b0);
`ifdef EXEC_UNIT_MUL_EN
        exec_multi("mul 9x7", OP_MUL, 2'd1, 2'd0, 4'd0, 4);
        flags("mul 9x7", 1'b0, 1'b0);
        out_chk("t6a", 8'h3F);
        exec1("ldr r0", OP_LDR, 2'd0, 2'd0, 4'd15, 1'b0);
        exec1("ldr r1", OP_LDR, 2'd1, 2'd0, 4'd15, 1'b0);
        exec_multi("mul 15x15", OP_MUL, 2'd1, 2'd0, 4'd0, 4);
        flags("mul 15x15", 1'b0, 1'b0);
        out_chk("t6b", 8'hE1);
`else
        exec1("mul nop", OP_MUL, 2'd1, 2'd0, 4'd0, 1'b0);
        flags("mul nop", 1'b0, 1'b0);
        out_chk("t6", 8'h09);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
